// File: rtl/grf_wport_arb_pkg.sv
// Shared types and constants for the GRF write-port arbiter.
// The write-request layout {wa, wd, pc} is the FIFO entry format.
package grf_wport_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] GRF_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wa;
        logic [DATA_W-1:0]     wd;
        logic [DATA_W-1:0]     pc;
    } wreq_t;

    localparam int WREQ_W = $bits(wreq_t);

    function automatic logic [(1<<REG_ADDR_W)-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] wa);
        reg_onehot = {{((1<<REG_ADDR_W)-1){1'b0}}, 1'b1} << wa;
    endfunction

endpackage

// File: rtl/grf_wport_arb_wb_fifo.sv
// DEPTH x wreq_t synchronous FIFO buffering long-latency writebacks.
// Exposes occupancy, the head entry and per-slot valid/wa for hazard tracking.
module grf_wport_arb_wb_fifo
    import grf_wport_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  push,
    input  wreq_t                                 push_data,
    input  logic                                  pop,
    output wreq_t                                 head,
    output logic [$clog2(DEPTH):0]                count,
    output logic [DEPTH-1:0]                      entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_wa
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    wreq_t            mem [DEPTH];

    // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: storage is not reset; a slot only matters once entry_valid marks it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PTR_W-1:0] off;
        assign off            = PTR_W'(i) - rd_ptr;
        assign entry_valid[i] = {1'b0, off} < count;
        assign entry_wa[i]    = mem[i].wa;
    end

endmodule

// File: rtl/grf_wport_arb.sv
// Arbitrates the GRF write port: W stage first, buffered long-latency writes fill idle slots.
// Optional starvation stall controlled by macro GRF_WARB_AGE_EN.
module grf_wport_arb
    import grf_wport_arb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AGE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p_we,
    input  logic [REG_ADDR_W-1:0] p_wa,
    input  logic [DATA_W-1:0]     p_wd,
    input  logic [DATA_W-1:0]     p_pc,
    input  logic                  l_valid,
    input  logic [REG_ADDR_W-1:0] l_wa,
    input  logic [DATA_W-1:0]     l_wd,
    input  logic [DATA_W-1:0]     l_pc,
    output logic                  l_ready,
    output logic                  grf_we,
    output logic [REG_ADDR_W-1:0] grf_wa,
    output logic [DATA_W-1:0]     grf_wd,
    output logic [DATA_W-1:0]     grf_wpc,
    output logic [31:0]           pend_mask,
    output logic                  stall_req
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                           p_act;
    logic                           push;
    logic                           pop;
    wreq_t                          head;
    logic [CNT_W-1:0]               count;
    logic [DEPTH-1:0]               entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_wa;

    assign l_ready = (count < CNT_W'(DEPTH));
    assign p_act   = p_we && (p_wa != GRF_ZERO);
    // l_wa==0 still completes the handshake but is dropped here.
    assign push    = l_valid && l_ready && (l_wa != GRF_ZERO);
    assign pop     = !p_act && (count != '0);

    grf_wport_arb_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_data   ('{wa: l_wa, wd: l_wd, pc: l_pc}),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_wa    (entry_wa)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grf_we  <= 1'b0;
            grf_wa  <= '0;
            grf_wd  <= '0;
            grf_wpc <= '0;
        end else if (p_act) begin
            grf_we  <= 1'b1;
            grf_wa  <= p_wa;
            grf_wd  <= p_wd;
            grf_wpc <= p_pc;
        end else if (pop) begin
            grf_we  <= 1'b1;
            grf_wa  <= head.wa;
            grf_wd  <= head.wd;
            grf_wpc <= head.pc;
        end else begin
            grf_we  <= 1'b0;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) pend_mask = pend_mask | reg_onehot(entry_wa[i]);
        end
        pend_mask[0] = 1'b0;
    end

`ifdef GRF_WARB_AGE_EN
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    logic [AGE_W-1:0] age;
    logic [AGE_W-1:0] age_d;
    logic             stall_q;

    // Head wait time: saturating, cleared whenever the head leaves or the FIFO is empty.
    always_comb begin
        age_d = age;
        if (pop || count == '0) begin
            age_d = '0;
        end else if (age < AGE_W'(AGE_MAX)) begin
            age_d = age + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age     <= '0;
            stall_q <= 1'b0;
        end else begin
            age     <= age_d;
            stall_q <= (age_d >= AGE_W'(AGE_MAX));
        end
    end

    assign stall_req = stall_q;
`else
    // Always 0 for any legal AGE_MAX; the threshold only matters with the age counter built.
    assign stall_req = (AGE_MAX < 0);
`endif

endmodule

// File: doc/grf_wport_arb.md
Name: grf_wport_arb

Overview:
- Arbitrates the single GRF write port between two producers.
  - Pipeline W stage: highest priority, never back-pressured.
  - Long-latency unit (mult/div result return): buffered, lower priority.
- Buffers long-latency writebacks in a small FIFO and drains them into idle W-stage slots.
- Exports a pending-register mask so decode can stall readers and writers of registers whose writes are still buffered.
- Sits between W stage / MDU and the GRF write inputs (RegWrite, WA, WD, WPC).

Parameters:
- DEPTH, 4, number of FIFO entries for long-latency writes; power of two, at least 2.
- AGE_MAX, 8, number of cycles the head entry may wait before a starvation stall is requested.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- p_we  in  1  W-stage write request.
- p_wa  in  5  W-stage destination register.
- p_wd  in  32  W-stage write data.
- p_pc  in  32  W-stage instruction PC.
- l_valid  in  1  long-latency write request.
- l_wa  in  5  long-latency destination register.
- l_wd  in  32  long-latency write data.
- l_pc  in  32  long-latency instruction PC.
- l_ready  out  1  FIFO can accept an entry this cycle.
- grf_we  out  1  registered GRF RegWrite.
- grf_wa  out  5  registered GRF WA.
- grf_wd  out  32  registered GRF WD.
- grf_wpc  out  32  registered GRF WPC.
- pend_mask  out  32  bit r set while any valid FIFO entry targets register r; bit 0 is always 0.
- stall_req  out  1  asks the pipeline to inject W-stage bubbles.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied; count=0; read and write pointers at 0; age=0.
  - grf_we=0; grf_wa=0; grf_wd=0; grf_wpc=0; pend_mask=0; stall_req=0; l_ready=1.
- Effective requests:
  - p_act = p_we && p_wa!=0.
  - l_act = l_valid && l_ready && l_wa!=0.
  - l_valid with l_wa==0 and l_ready=1 counts as a handshake but is discarded, not buffered.
- l_ready = (count < DEPTH). It is combinational from the count register only; it does not look ahead to a same-cycle pop.
- Grant, evaluated each cycle:
  - If p_act: the output registers load p_wa/p_wd/p_pc with grf_we=1 next cycle.
  - Else if count>0: pop the head entry; the output registers load it with grf_we=1.
  - Else: grf_we=0 next cycle, with wa/wd/wpc holding their previous values.
- Latency:
  - Pipeline write: exactly 1 cycle, request at cycle N gives grf_we=1 during N+1.
  - Long-latency write: minimum 2 cycles. A push at N can be popped no earlier than N+1 and appears on grf_we at N+2. There is no FIFO bypass.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal even when count==DEPTH-... any count, including 1, because the pop takes the existing head.
- Pointers wrap modulo DEPTH.
- Ordering: entries drain strictly in FIFO order. Pipeline writes are never reordered against each other.
- pend_mask:
  - OR of one-hot(wa) over the valid entries, recomputed from registered FIFO state (combinational from flops).
  - A popped entry's bit clears in the cycle its write is on grf_we. GRF internal bypass covers same-cycle reads of that value.
  - Duplicate wa values in the FIFO are allowed; the bit stays set until the last such entry pops.
- WAW hazard:
  - Decode must not issue a write to any register r with pend_mask[r]=1.
  - If it does anyway, writes land in grant order and no squash is performed.
- Age counter:
  - Increments each cycle count>0 and no pop occurs; saturates at AGE_MAX.
  - Cleared on any pop and when count==0.
- Reset asserted mid-drain: in-flight and buffered entries are lost, and grf_we drops to 0 immediately (asynchronous).

Optional Feature:
- Macro: GRF_WARB_AGE_EN.
- Defined:
  - stall_req = (age >= AGE_MAX), registered.
  - stall_req stays 1 until the head entry pops, then drops the cycle after the pop.
- Not defined:
  - stall_req is tied to 0 and the age counter is not instantiated.
  - A long-latency entry may wait indefinitely under back-to-back W-stage writes.

Decomposition:
- Shared package/header holds:
  - REG_ADDR_W=5, DATA_W=32.
  - The write-request struct or field layout {wa, wd, pc}.
  - The GRF_ZERO register constant.
- One natural sub-module: wb_fifo, a parameterised DEPTH x 69-bit synchronous FIFO with count, push/pop and entry-valid vector. The top level holds the grant logic, output registers, pend_mask and age logic.

Test Plan:
- Reset sequencing: hold reset=0 with l_valid=1 and p_we=1, then release.
  - Expect all outputs at their reset values during reset.
  - Expect the first grf_we=1 one cycle after the first post-reset request.
- Pipeline-only traffic: p_we=1, p_wa=5, p_wd=0x1234, p_pc=0x3000 at cycle N.
  - Expect grf_we=1, grf_wa=5, grf_wd=0x1234, grf_wpc=0x3000 at N+1.
  - Expect p_wa=0 to produce grf_we=0.
- Drain into an idle slot: l_valid=1, l_wa=8, l_wd=0xAA at N, with p_we=0.
  - Expect pend_mask[8]=1 at N+1.
  - Expect grf_we=1, wa=8, wd=0xAA at N+2, with pend_mask[8]=0.
- Full and priority: push 4 entries (wa=1..4) while p_we=1 continuously.
  - Expect l_ready=0 after the 4th push and pend_mask=0x1E.
  - Drop p_we and expect 4 consecutive grf writes with wa=1,2,3,4.
- Simultaneous push and pop at count=2 with p_we=0.
  - Expect count unchanged, head popped, and the new entry appended at the tail.
- With GRF_WARB_AGE_EN and AGE_MAX=8: 1 entry buffered and p_we=1 held for 10 cycles.
  - Expect stall_req=1 from the 9th cycle.
  - Release p_we, expect the entry to drain and stall_req=0 on the following cycle.
